// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus dispatcher: FSM state encoding,
// access op codes and the default WAIT timeout.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int TMO_DEFAULT = 255;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/bus_dispatcher_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] slot;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        slot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[slot]) begin
                valid       = 1'b1;
                idx         = slot;
                grant[slot] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_dispatcher.sv
// Round-robin dispatcher for the shared memory bus: one access at a time,
// with a lock that lets the current owner chain accesses.
module bus_dispatcher
    import bus_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO    = TMO_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        disp_online,
    output logic                    is_bus_busy,
    output logic [ADDR_W-1:0]       addr,
    output logic [DATA_W-1:0]       data,
    output logic                    read_dn,
    output logic                    write_dn,
    output logic                    bus_err,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state, state_next;
    op_e                op;
    logic [IDX_W-1:0]   ptr, lock_owner, win_idx, pick_idx;
    logic               lock_valid, pick_valid, err, timeout;
    logic [N_REQ-1:0]   grant_r, pick_grant, eligible, lock_mask;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r, data_r;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic [ADDR_W-1:0]  addr_slot  [N_REQ];
    logic [DATA_W-1:0]  wdata_slot [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign addr_slot[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_slot[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // A held lock narrows eligibility to the owner; dropping it reverts to round-robin at once.
    assign lock_mask = N_REQ'(1) << lock_owner;
    assign eligible  = (lock_valid && req_lock[lock_owner])
                     ? ((req_read | req_write) & lock_mask)
                     : (req_read | req_write);

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (eligible),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        cnt_inc    = cnt + CNT_W'(1);
        case (state)
            ST_IDLE:  if (pick_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack) begin
                    state_next = ST_DONE;
                end else if (cnt_inc == CNT_W'(TMO)) begin
                    state_next = ST_DONE;
                    timeout    = 1'b1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            win_idx    <= '0;
            grant_r    <= '0;
            op         <= OP_READ;
            addr_r     <= '0;
            wdata_r    <= '0;
            data_r     <= '0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        win_idx <= pick_idx;
                        grant_r <= pick_grant;
                        op      <= req_write[pick_idx] ? OP_WRITE : OP_READ;
                        addr_r  <= addr_slot[pick_idx];
                        wdata_r <= wdata_slot[pick_idx];
                        data_r  <= req_write[pick_idx] ? wdata_slot[pick_idx] : '0;
                        err     <= 1'b0;
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    if (mem_ack) begin
                        if (op == OP_READ) data_r <= mem_rdata;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout) err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    grant_r <= '0;
                    if (req_lock[win_idx]) begin
                        lock_valid <= 1'b1;
                        lock_owner <= win_idx;
                    end else begin
                        lock_valid <= 1'b0;
                        ptr        <= (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_bus_busy = (state != ST_IDLE);
    assign disp_online = is_bus_busy ? grant_r : '0;
    assign addr        = is_bus_busy ? addr_r : '0;
    assign data        = (state == ST_DONE) ? data_r : '0;
    assign read_dn     = (state == ST_DONE) && (op == OP_READ);
    assign write_dn    = (state == ST_DONE) && (op == OP_WRITE);
    assign bus_err     = (state == ST_DONE) && err;
    assign mem_rd      = (state == ST_ISSUE) && (op == OP_READ);
    assign mem_wr      = (state == ST_ISSUE) && (op == OP_WRITE);
    assign mem_addr    = addr;
    assign mem_wdata   = (is_bus_busy && op == OP_WRITE) ? wdata_r : '0;

endmodule
